// File: rtl/atm_pkg.sv
// atm_pkg: shared constants, FSM state type and switch-decoding helpers
// for the ATM deposit accumulator slice.
//   BILL_VALUE  : denomination of switch i (8 entries, switch 0 = $1)
//   qstate_e    : bill qualification FSM states
//   ATM_AMT_W   : default width of amount/balance buses
package atm_pkg;

  localparam int ATM_AMT_W = 16;

  localparam logic [15:0] BILL_VALUE [8] = '{16'd1, 16'd5, 16'd10, 16'd20,
                                             16'd50, 16'd100, 16'd200, 16'd500};

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DEPOSIT,
    S_WAIT_REL,
    S_ERROR
  } qstate_e;

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Two or more bits set (clearing the lowest set bit leaves something).
  function automatic logic is_multihot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  // Bit position of a one-hot value (highest set bit otherwise).
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/atm_bill_qual.sv
// atm_bill_qual: bill switch qualifier. A one-hot switch value must be
// stable for HOLD_CYCLES consecutive samples before it is accepted; the
// accept strobe is high for the single DEPOSIT cycle. Multi-hot values
// park the FSM in ERROR until all switches are released.
//   clk, rst : clock, async active-high reset
//   switch   : bill switches (NUM_BILLS wide)
//   state    : current FSM state
//   idx      : latched bill index
//   accept   : high while in DEPOSIT (registered)
//   err      : high while in ERROR (registered)
module atm_bill_qual
  import atm_pkg::*;
#(
  parameter int NUM_BILLS   = 6,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BILLS-1:0] switch,
  output qstate_e              state,
  output logic [2:0]           idx,
  output logic                 accept,
  output logic                 err
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [7:0]    sw8;
  logic [CW-1:0] cnt;
  logic          sw_zero, sw_one, sw_multi;
  logic [2:0]    sw_idx;

  always_comb begin
    sw8 = '0;
    sw8[NUM_BILLS-1:0] = switch;
  end

  assign sw_zero  = (sw8 == 8'd0);
  assign sw_one   = is_onehot(sw8);
  assign sw_multi = is_multihot(sw8);
  assign sw_idx   = onehot_idx(sw8);

  // accept/err are registered alongside state so they match it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      accept <= 1'b0;
      err    <= 1'b0;
    end else begin
      accept <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sw_multi) begin
            state <= S_ERROR;
            err   <= 1'b1;
          end else if (sw_one) begin
            idx <= sw_idx;
            cnt <= CW'(1);
            if (HOLD_CYCLES == 1) begin
              state  <= S_DEPOSIT;
              accept <= 1'b1;
            end else begin
              state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (sw_zero) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (sw_multi) begin
            state <= S_ERROR;
            cnt   <= '0;
            err   <= 1'b1;
          end else if (sw_idx == idx) begin
            cnt <= cnt + CW'(1);
            if (cnt + CW'(1) == CW'(HOLD_CYCLES)) begin
              state  <= S_DEPOSIT;
              accept <= 1'b1;
            end
          end else begin
            // A different bill restarts the hold window.
            idx <= sw_idx;
            cnt <= CW'(1);
          end
        end
        S_DEPOSIT: begin
          // Switch is ignored here; release is only looked for in WAIT_REL.
          state <= S_WAIT_REL;
          cnt   <= '0;
        end
        S_WAIT_REL: begin
          if (sw_zero) begin
            state <= S_IDLE;
          end else if (sw_multi) begin
            state <= S_ERROR;
            err   <= 1'b1;
          end
        end
        S_ERROR: begin
          if (sw_zero) state <= S_IDLE;
          else         err   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/atm_deposit_accumulator.sv
// atm_deposit_accumulator: qualifies bill switches (atm_bill_qual) and
// keeps a saturating balance with withdrawal handling.
// Optional feature macro: ATM_DEP_COUNT_EN adds dep_count[15:0], a
// saturating count of accepted deposits.
//   clk, rst      : clock, async active-high reset
//   switch        : bill switches
//   clear         : synchronous balance clear (highest priority)
//   wd_req/wd_amt : withdrawal strobe and amount
//   balance       : registered balance, capped at MAX_BAL
//   bill_amount   : value of the bill being qualified/held, else 0
//   deposit_pulse : one strobe per accepted deposit, aligned with balance
//   wd_ack/nack   : withdrawal performed / refused (next cycle)
//   led_multi     : FSM is in ERROR (multi-switch)
//   sat           : sticky, a deposit was clipped at MAX_BAL
module atm_deposit_accumulator
  import atm_pkg::*;
#(
  parameter int NUM_BILLS   = 6,
  parameter int AMT_W       = ATM_AMT_W,
  parameter int MAX_BAL     = 9999,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BILLS-1:0] switch,
  input  logic                 clear,
  input  logic                 wd_req,
  input  logic [AMT_W-1:0]     wd_amt,
  output logic [AMT_W-1:0]     balance,
  output logic [AMT_W-1:0]     bill_amount,
  output logic                 deposit_pulse,
  output logic                 wd_ack,
  output logic                 wd_nack,
  output logic                 led_multi,
`ifdef ATM_DEP_COUNT_EN
  output logic [15:0]          dep_count,
`endif
  output logic                 sat
);

  localparam logic [AMT_W:0] MAXB = (AMT_W+1)'(MAX_BAL);

  qstate_e          state;
  logic [2:0]       idx;
  logic             accept;
  logic [AMT_W-1:0] val;
  logic [AMT_W:0]   sum;
  logic             clip;
  logic [AMT_W-1:0] b_dep;
  logic             held;

  atm_bill_qual #(
    .NUM_BILLS  (NUM_BILLS),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_qual (
    .clk   (clk),
    .rst   (rst),
    .switch(switch),
    .state (state),
    .idx   (idx),
    .accept(accept),
    .err   (led_multi)
  );

  // Deposit is applied first (with one spare bit for the saturation check);
  // a same-cycle withdrawal is then judged against b_dep.
  always_comb begin
    val   = AMT_W'(BILL_VALUE[idx]);
    sum   = {1'b0, balance} + {1'b0, val};
    clip  = accept && (sum > MAXB);
    b_dep = balance;
    if (accept) b_dep = clip ? MAXB[AMT_W-1:0] : sum[AMT_W-1:0];
    held  = (state == S_COUNT) || (state == S_DEPOSIT) || (state == S_WAIT_REL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      balance       <= '0;
      bill_amount   <= '0;
      deposit_pulse <= 1'b0;
      wd_ack        <= 1'b0;
      wd_nack       <= 1'b0;
      sat           <= 1'b0;
`ifdef ATM_DEP_COUNT_EN
      dep_count     <= '0;
`endif
    end else begin
      deposit_pulse <= accept;
      bill_amount   <= held ? val : '0;
      wd_ack        <= 1'b0;
      wd_nack       <= 1'b0;
      if (clear) begin
        // Deposit is dropped; a zero withdrawal still trivially succeeds.
        balance <= '0;
        sat     <= 1'b0;
        if (wd_req) begin
          wd_ack  <= (wd_amt == '0);
          wd_nack <= (wd_amt != '0);
        end
`ifdef ATM_DEP_COUNT_EN
        dep_count <= '0;
`endif
      end else begin
        if (clip) sat <= 1'b1;
        if (wd_req && (wd_amt <= b_dep)) begin
          balance <= b_dep - wd_amt;
          wd_ack  <= 1'b1;
        end else begin
          balance <= b_dep;
          wd_nack <= wd_req;
        end
`ifdef ATM_DEP_COUNT_EN
        if (accept && (dep_count != 16'hFFFF)) dep_count <= dep_count + 16'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_atm_deposit_accumulator.sv
// Bench for atm_deposit_accumulator: directed plan steps followed by a
// random phase, every cycle checked against a behavioural model.
module tb_atm_deposit_accumulator;

  localparam int NB   = 6;
  localparam int AW   = 16;
  localparam int MAXB = 9999;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] switch;
  logic          clear, wd_req;
  logic [AW-1:0] wd_amt;
  logic [AW-1:0] balance, bill_amount;
  logic          deposit_pulse, wd_ack, wd_nack, led_multi, sat;
`ifdef ATM_DEP_COUNT_EN
  logic [15:0]   dep_count;
`endif

  atm_deposit_accumulator #(
    .NUM_BILLS(NB), .AMT_W(AW), .MAX_BAL(MAXB), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .switch(switch), .clear(clear),
    .wd_req(wd_req), .wd_amt(wd_amt), .balance(balance),
    .bill_amount(bill_amount), .deposit_pulse(deposit_pulse),
    .wd_ack(wd_ack), .wd_nack(wd_nack), .led_multi(led_multi),
`ifdef ATM_DEP_COUNT_EN
    .dep_count(dep_count),
`endif
    .sat(sat)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mism     = 0;
  int bill_v [8] = '{1, 5, 10, 20, 50, 100, 200, 500};

  // Model: balance and flags, plus the qualification history.
  // m_run  : consecutive samples of the current one-hot bill
  // m_pend : a deposit is applied at the next edge (sample there ignored)
  // m_wait : bill already deposited, waiting for all switches released
  // m_err  : multi-switch seen, waiting for release
  int m_bal, m_run, m_idx, m_sat, m_pend, m_wait, m_err, m_cnt;
  int e_dp, e_ack, e_nack, e_bill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [NB-1:0] s);
    int r = 0;
    for (int i = 0; i < NB; i++) if (s[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_bal = 0; m_run = 0; m_idx = 0; m_sat = 0;
    m_pend = 0; m_wait = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int val, b, n1, k;
    bit clip;
    val    = bill_v[m_idx];
    e_bill = (m_run > 0 || m_pend != 0 || m_wait != 0) ? val : 0;
    e_dp   = m_pend;
    b      = m_bal;
    clip   = 0;
    if (m_pend != 0) begin
      b = m_bal + val;
      if (b > MAXB) begin b = MAXB; clip = 1; end
    end
    e_ack = 0; e_nack = 0;
    if (clear) begin
      m_bal = 0; m_sat = 0; m_cnt = 0;
      if (wd_req) begin
        if (wd_amt == 0) e_ack = 1; else e_nack = 1;
      end
    end else begin
      if (clip) m_sat = 1;
      if (m_pend != 0 && m_cnt < 65535) m_cnt++;
      m_bal = b;
      if (wd_req) begin
        if (int'(wd_amt) <= b) begin m_bal = b - int'(wd_amt); e_ack = 1; end
        else e_nack = 1;
      end
    end
    n1 = $countones(switch);
    if (m_pend != 0) m_pend = 0;
    else if (m_err != 0) begin
      if (n1 == 0) m_err = 0;
    end else if (m_wait != 0) begin
      if (n1 == 0) m_wait = 0;
      else if (n1 > 1) begin m_wait = 0; m_err = 1; end
    end else if (n1 == 0) m_run = 0;
    else if (n1 > 1) begin m_run = 0; m_err = 1; end
    else begin
      k = idx_of(switch);
      if (m_run > 0 && k == m_idx) m_run++;
      else begin m_run = 1; m_idx = k; end
      if (m_run == HOLD) begin m_pend = 1; m_wait = 1; m_run = 0; end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("balance", 32'(balance), m_bal);
    chk("deposit_pulse", 32'(deposit_pulse), e_dp);
    chk("wd_ack", 32'(wd_ack), e_ack);
    chk("wd_nack", 32'(wd_nack), e_nack);
    chk("led_multi", 32'(led_multi), m_err);
    chk("sat", 32'(sat), m_sat);
    chk("bill_amount", 32'(bill_amount), e_bill);
`ifdef ATM_DEP_COUNT_EN
    chk("dep_count", 32'(dep_count), m_cnt);
`endif
  endtask

  task automatic dep(input int k);
    switch = '0;
    switch[k] = 1'b1;
    repeat (HOLD) cyc();
    switch = '0;
    repeat (2) cyc();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    int a, b2, len, r, pulses;
    rst = 1'b1; switch = '0; clear = 1'b0; wd_req = 1'b0; wd_amt = '0;
    model_reset();
    #12;
    chk("reset_balance", 32'(balance), 0);
    chk("reset_led", 32'(led_multi), 0);
    chk("reset_pulse", 32'(deposit_pulse), 0);
    rst = 1'b0;
    cyc();

    // 1: $10 held for the full window.
    switch = 6'b000100;
    repeat (3) cyc();
    chk("t1_bill_held", 32'(bill_amount), 10);
    cyc();
    switch = '0;
    repeat (3) cyc();
    chk("t1_balance", 32'(balance), 10);
    chk("t1_bill_released", 32'(bill_amount), 0);

    // 2: short hold, then bill change mid-count.
    do_clear();
    switch = 6'b000100;
    repeat (3) cyc();
    switch = '0;
    repeat (2) cyc();
    chk("t2_short_hold", 32'(balance), 0);
    switch = 6'b000001;
    repeat (2) cyc();
    switch = 6'b000010;
    repeat (HOLD) cyc();
    switch = '0;
    repeat (2) cyc();
    chk("t2_restart", 32'(balance), 5);

    // 3: multi-hot.
    switch = 6'b100001;
    cyc();
    chk("t3_led_on", 32'(led_multi), 1);
    repeat (5) cyc();
    switch = '0;
    cyc();
    chk("t3_led_off", 32'(led_multi), 0);
    cyc();
    chk("t3_balance", 32'(balance), 5);

    // 4: saturation, then clear.
    do_clear();
    repeat (99) dep(5);
    dep(4);
    chk("t4_pre", 32'(balance), 9950);
    dep(5);
    chk("t4_sat_bal", 32'(balance), 9999);
    chk("t4_sat_flag", 32'(sat), 1);
    do_clear();
    chk("t4_clear_bal", 32'(balance), 0);
    chk("t4_clear_sat", 32'(sat), 0);

    // 5: withdrawals, including one in a DEPOSIT cycle.
    dep(3);
    dep(2);
    wd_req = 1'b1; wd_amt = 16'd50;
    cyc();
    wd_amt = 16'd20;
    cyc();
    wd_req = 1'b0;
    cyc();
    chk("t5_after_wd", 32'(balance), 10);
    switch = 6'b001000;
    repeat (HOLD) cyc();
    switch = '0;
    wd_req = 1'b1; wd_amt = 16'd25;
    cyc();
    chk("t5_dep_wd_ack", 32'(wd_ack), 1);
    wd_req = 1'b0;
    cyc();
    chk("t5_dep_wd_bal", 32'(balance), 5);

    // 6: reset in the middle of COUNT, switch held through release.
    switch = 6'b000100;
    repeat (2) cyc();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_balance", 32'(balance), 0);
    chk("t6_rst_bill", 32'(bill_amount), 0);
    chk("t6_rst_flags", 32'({deposit_pulse, wd_ack, wd_nack, led_multi, sat}), 0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    repeat (HOLD) begin cyc(); pulses += int'(deposit_pulse); end
    chk("t6_no_early_dep", pulses, 0);
    cyc();
    chk("t6_dep_pulse", 32'(deposit_pulse), 1);
    chk("t6_balance", 32'(balance), 10);
    switch = '0;
    repeat (2) cyc();

    // Random phase.
    repeat (80) begin
      r = $urandom_range(0, 99);
      switch = '0;
      if (r >= 40 && r < 85) switch[$urandom_range(0, NB-1)] = 1'b1;
      else if (r >= 85) begin
        a  = $urandom_range(0, NB-1);
        b2 = (a + 1 + $urandom_range(0, NB-2)) % NB;
        switch[a] = 1'b1; switch[b2] = 1'b1;
      end
      len = $urandom_range(1, 6);
      repeat (len) begin
        wd_req = ($urandom_range(0, 3) == 0);
        wd_amt = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, 60));
        clear  = ($urandom_range(0, 39) == 0);
        cyc();
      end
    end
    switch = '0; wd_req = 1'b0; clear = 1'b0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
